rsa_job_scheduler: RTL and testbench

RSA_JOB_SCHEDULER -- requirements
Module: rsa_job_scheduler

---
 rtl/rsa_job_scheduler_if.sv | 42 ++++
 rtl/rsa_job_scheduler.sv | 129 ++++++++++++
 tb/tb_rsa_job_scheduler.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/rsa_job_scheduler_if.sv
// Job request/response and datapath bundle for the RSA job scheduler.
// Slave side is the scheduler; master side is the requesters plus the engine.
interface rsa_job_scheduler_if #(
  parameter int WordSize = 32
);
  logic [1:0]            req_valid;
  logic [2*WordSize-1:0] req_text;
  logic [2*WordSize-1:0] req_key;
  logic [2*WordSize-1:0] req_mod;
  logic [1:0]            req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_id;
  logic [WordSize-1:0]   rsp_text;
  logic                  rsp_timeout;
  logic                  busy;
  logic [WordSize-1:0]   dp_input_text;
  logic [WordSize-1:0]   dp_key;
  logic [WordSize-1:0]   dp_mod;
  logic                  dp_load;
  logic                  dp_running;
  logic                  dp_over;
  logic [WordSize-1:0]   dp_output_text;

  modport master (
    output req_valid, req_text, req_key, req_mod,
    output rsp_ready, dp_over, dp_output_text,
    input  req_ready, rsp_valid, rsp_id, rsp_text,
    input  rsp_timeout, busy,
    input  dp_input_text, dp_key, dp_mod,
    input  dp_load, dp_running
  );

  modport slave (
    input  req_valid, req_text, req_key, req_mod,
    input  rsp_ready, dp_over, dp_output_text,
    output req_ready, rsp_valid, rsp_id, rsp_text,
    output rsp_timeout, busy,
    output dp_input_text, dp_key, dp_mod,
    output dp_load, dp_running
  );
endinterface

// File: rtl/rsa_job_scheduler.sv
// Two-requester round-robin job scheduler for a modexp datapath.
// One job in flight: IDLE -> LOAD -> RUN -> RESP, with RUN timeout.
module rsa_job_scheduler #(
  parameter int WordSize      = 32,
  parameter int LoadCycles    = 2,
  parameter int TimeoutCycles = 4096
) (
  input logic                clk,
  input logic                reset,
  rsa_job_scheduler_if.slave bus
);
  localparam int LW = (LoadCycles > 1) ? $clog2(LoadCycles) : 1;
  localparam int TW = $clog2(TimeoutCycles);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

  state_t              state, state_nxt;
  logic                prio;
  logic [LW-1:0]       load_cnt;
  logic [TW-1:0]       run_cnt;
  logic                grant_vld, grant_id, accept;
  logic                load_done, run_last;
  logic [WordSize-1:0] text_q, key_q, mod_q, rsp_text_q;
  logic                rsp_id_q, rsp_to_q;

  assign load_done = (load_cnt == LW'(LoadCycles - 1));
  assign run_last  = (run_cnt == TW'(TimeoutCycles - 1));

  always_comb begin
    state_nxt      = state;
    grant_vld      = 1'b0;
    grant_id       = prio;
    accept         = 1'b0;
    bus.req_ready  = 2'b00;
    bus.dp_load    = 1'b0;
    bus.dp_running = 1'b0;
    bus.rsp_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_valid[prio]) begin
          grant_vld = 1'b1;
          grant_id  = prio;
        end else if (bus.req_valid[~prio]) begin
          grant_vld = 1'b1;
          grant_id  = ~prio;
        end
        // reset gates the grant so req_ready reads 0 while held in reset
        accept = grant_vld && reset;
        if (accept) begin
          bus.req_ready = 2'b01 << grant_id;
          state_nxt     = LOAD;
        end
      end
      LOAD: begin
        bus.dp_load = 1'b1;
        if (load_done) state_nxt = RUN;
      end
      RUN: begin
        bus.dp_running = 1'b1;
        if (bus.dp_over || run_last) state_nxt = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio       <= 1'b0;
      load_cnt   <= '0;
      run_cnt    <= '0;
      text_q     <= '0;
      key_q      <= '0;
      mod_q      <= '0;
      rsp_text_q <= '0;
      rsp_id_q   <= 1'b0;
      rsp_to_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            text_q   <= grant_id ? bus.req_text[2*WordSize-1:WordSize]
                                 : bus.req_text[WordSize-1:0];
            key_q    <= grant_id ? bus.req_key[2*WordSize-1:WordSize]
                                 : bus.req_key[WordSize-1:0];
            mod_q    <= grant_id ? bus.req_mod[2*WordSize-1:WordSize]
                                 : bus.req_mod[WordSize-1:0];
            rsp_id_q <= grant_id;
            load_cnt <= '0;
          end
        end
        LOAD: begin
          load_cnt <= load_cnt + 1'b1;
          if (load_done) run_cnt <= '0;
        end
        RUN: begin
          // completion wins over a coincident timeout
          if (bus.dp_over) begin
            rsp_text_q <= bus.dp_output_text;
            rsp_to_q   <= 1'b0;
          end else if (run_last) begin
            rsp_text_q <= '0;
            rsp_to_q   <= 1'b1;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) prio <= ~rsp_id_q;
        end
      endcase
    end
  end

  assign bus.busy          = (state != IDLE);
  assign bus.rsp_id        = rsp_id_q;
  assign bus.rsp_text      = rsp_text_q;
  assign bus.rsp_timeout   = rsp_to_q;
  assign bus.dp_input_text = text_q;
  assign bus.dp_key        = key_q;
  assign bus.dp_mod        = mod_q;
endmodule

// File: tb/tb_rsa_job_scheduler.sv
// Directed vector bench for rsa_job_scheduler.
// Table of jobs plus hand-written reset sequences.
module tb_rsa_job_scheduler;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rsa_job_scheduler_if #(.WordSize(W)) bus ();

  rsa_job_scheduler #(
    .WordSize(W),
    .LoadCycles(2),
    .TimeoutCycles(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [1:0]   valid;
    logic [W-1:0] text;
    logic [W-1:0] key;
    logic [W-1:0] mod;
    int           over_at;
    bit           load_over;
    logic [W-1:0] out;
    int           hold;
    logic         exp_id;
    logic [W-1:0] exp_text;
    logic         exp_to;
    int           exp_runs;
    int           exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run_job(input vec_t v);
    int           loads, runs, lat;
    bit           seen, stable;
    logic [W-1:0] et, ek, em;
    bus.req_valid      = v.valid;
    bus.req_text       = {v.text ^ 32'hF0F0, v.text};
    bus.req_key        = {v.key ^ 32'hF0F0, v.key};
    bus.req_mod        = {v.mod ^ 32'hF0F0, v.mod};
    bus.dp_over        = 1'b0;
    bus.dp_output_text = v.out;
    bus.rsp_ready      = 1'b0;
    et = v.exp_id ? v.text ^ 32'hF0F0 : v.text;
    ek = v.exp_id ? v.key ^ 32'hF0F0 : v.key;
    em = v.exp_id ? v.mod ^ 32'hF0F0 : v.mod;
    #1;
    chk("grant", bus.req_ready, 2'b01 << v.exp_id);
    @(posedge clk);
    @(negedge clk);
    loads = 0;
    runs  = 0;
    lat   = 0;
    seen  = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      lat++;
      if (bus.rsp_valid) begin
        seen = 1'b1;
      end else begin
        if (bus.dp_load) loads++;
        if (bus.dp_running) runs++;
        bus.dp_over = (bus.dp_load && v.load_over) ||
                      (bus.dp_running && runs == v.over_at);
        @(negedge clk);
      end
    end
    bus.dp_over = 1'b0;
    chk("rsp_seen", seen, 1'b1);
    chk("load_cycles", loads, 2);
    chk("run_cycles", runs, v.exp_runs);
    chk("latency", lat, v.exp_lat);
    chk("rsp_id", bus.rsp_id, v.exp_id);
    chk("rsp_text", bus.rsp_text, v.exp_text);
    chk("rsp_timeout", bus.rsp_timeout, v.exp_to);
    chk("dp_operands", {bus.dp_input_text, bus.dp_key ^ bus.dp_mod},
        {et, ek ^ em});
    stable = 1'b1;
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      if (!(bus.rsp_valid && bus.rsp_id == v.exp_id &&
            bus.rsp_text == v.exp_text && bus.rsp_timeout == v.exp_to &&
            bus.req_ready == 2'b00 && bus.busy))
        stable = 1'b0;
    end
    if (v.hold > 0) chk("resp_hold", stable, 1'b1);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("back_idle", {bus.busy, bus.rsp_valid}, 2'b00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   hit, quiet;
    vec_t r;
    vecs[0] = '{2'b11, 4, 13, 497, 5, 1'b0, 445, 0,
                1'b0, 445, 1'b0, 5, 8};
    vecs[1] = '{2'b11, 'h10, 3, 'h99, 1, 1'b0, 'h1111, 0,
                1'b1, 'h1111, 1'b0, 1, 4};
    vecs[2] = '{2'b11, 'h20, 5, 'h77, 2, 1'b1, 'h2222, 10,
                1'b0, 'h2222, 1'b0, 2, 5};
    vecs[3] = '{2'b11, 'h30, 7, 'h55, 0, 1'b0, 'hdead, 0,
                1'b1, 0, 1'b1, 16, 19};
    vecs[4] = '{2'b10, 'h40, 9, 'h33, 16, 1'b0, 7, 0,
                1'b1, 7, 1'b0, 16, 19};
    vecs[5] = '{2'b11, 'h50, 11, 'h21, 3, 1'b0, 'h5555, 3,
                1'b0, 'h5555, 1'b0, 3, 6};
    vecs[6] = '{2'b01, 'h60, 2, 'h11, 1, 1'b0, 'h6666, 0,
                1'b0, 'h6666, 1'b0, 1, 4};

    reset              = 1'b0;
    bus.req_valid      = 2'b11;
    bus.req_text       = '1;
    bus.req_key        = '1;
    bus.req_mod        = '1;
    bus.rsp_ready      = 1'b0;
    bus.dp_over        = 1'b0;
    bus.dp_output_text = '1;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {bus.req_ready, bus.busy, bus.rsp_valid,
                     bus.dp_load, bus.dp_running, bus.rsp_timeout}, 0);
    chk("rst_data", {bus.rsp_text, bus.dp_input_text}, 0);
    chk("rst_dp", {bus.dp_key, bus.dp_mod}, 0);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) run_job(vecs[i]);

    bus.req_valid = 2'b11;
    @(posedge clk);
    @(negedge clk);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (bus.dp_running) hit = 1'b1;
      else @(negedge clk);
    end
    chk("reach_run", hit, 1'b1);
    reset = 1'b0;
    #1;
    chk("rst_mid_run", {bus.dp_running, bus.dp_load, bus.busy,
                        bus.rsp_valid}, 0);
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.busy) quiet = 1'b0;
    end
    chk("rst_no_rsp", quiet, 1'b1);
    reset = 1'b1;
    r = '{2'b11, 'h70, 4, 'h44, 2, 1'b0, 'h7777, 0,
          1'b0, 'h7777, 1'b0, 2, 5};
    run_job(r);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
